// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the muldiv issue block
//
// Contents:
//   XLEN_DEFAULT   default operand/result width
//   WAIT_CNT_W     width of the post-issue wait counter
//   muldiv_op_t    RISC-V M-extension funct3 encoding
//   issue_state_t  issue FSM states
//   wait_load()    clamps the MIN_WAIT parameter into the counter's legal range
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int MIN_WAIT_MAX = 4;
  localparam int WAIT_CNT_W   = 3;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } issue_state_t;

  // The divider/multiplier raises busy one cycle after the start pulse, so
  // at least one cycle must pass before busy is trusted; more than
  // MIN_WAIT_MAX is never needed.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int min_wait);
    int clamped;
    clamped = min_wait;
    if (clamped < 1) clamped = 1;
    if (clamped > MIN_WAIT_MAX) clamped = MIN_WAIT_MAX;
    return WAIT_CNT_W'(clamped);
  endfunction

endpackage

// File: rtl/muldiv_issue_if.sv
// rtl/muldiv_issue_if.sv - pipeline-side request/response channel of the muldiv issue block
//
// Signals:
//   req_valid/req_ready   request handshake (op, a, b)
//   req_op/req_a/req_b    operation and operands
//   resp_valid/resp_ready response handshake
//   resp_data             completed result
//   flush                 kill the current/pending operation
// Modports:
//   master  pipeline side (drives requests, consumes responses)
//   slave   muldiv_issue side
interface muldiv_issue_if #(
  parameter int XLEN = muldiv_pkg::XLEN_DEFAULT
) ();
  import muldiv_pkg::*;

  logic              req_valid;
  logic              req_ready;
  muldiv_op_t        req_op;
  logic [XLEN-1:0]   req_a;
  logic [XLEN-1:0]   req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic              flush;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, flush,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, flush,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/muldiv_result_cache.sv
// rtl/muldiv_result_cache.sv - single-entry result cache for muldiv_issue (MULDIV_RESULT_CACHE_EN)
//
// Ports:
//   clk, rst_n                     clock, async active-low reset (clears the tag)
//   invalidate                     drop the entry (any flush)
//   lookup_op/lookup_a/lookup_b    incoming request to compare against the tag
//   hit, hit_data                  tag match and the stored result
//   fill_en                        store a completed, non-flushed result
//   fill_op/fill_a/fill_b/fill_data tag and value to store
module muldiv_result_cache
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            invalidate,
  input  muldiv_op_t      lookup_op,
  input  logic [XLEN-1:0] lookup_a,
  input  logic [XLEN-1:0] lookup_b,
  output logic            hit,
  output logic [XLEN-1:0] hit_data,
  input  logic            fill_en,
  input  muldiv_op_t      fill_op,
  input  logic [XLEN-1:0] fill_a,
  input  logic [XLEN-1:0] fill_b,
  input  logic [XLEN-1:0] fill_data
);

  logic            tag_valid_q;
  muldiv_op_t      tag_op_q;
  logic [XLEN-1:0] tag_a_q;
  logic [XLEN-1:0] tag_b_q;
  logic [XLEN-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q <= 1'b0;
      tag_op_q    <= MUL;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
      data_q      <= '0;
    end else if (invalidate) begin
      // A flush may race a completion; the flushed result must never be
      // served, so invalidation wins over fill.
      tag_valid_q <= 1'b0;
    end else if (fill_en) begin
      tag_valid_q <= 1'b1;
      tag_op_q    <= fill_op;
      tag_a_q     <= fill_a;
      tag_b_q     <= fill_b;
      data_q      <= fill_data;
    end
  end

  assign hit      = tag_valid_q && (tag_op_q == lookup_op) &&
                    (tag_a_q == lookup_a) && (tag_b_q == lookup_b);
  assign hit_data = data_q;

endmodule

// File: rtl/muldiv_issue.sv
// rtl/muldiv_issue.sv - initiator for one alu_muldiv: issue, wait on busy, hold response
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   pipe              muldiv_issue_if.slave: req_*/resp_*/flush from the pipeline
//   md_op             operation to alu_muldiv (stable from ISSUE until WAIT/DRAIN ends)
//   md_input_valid    one-cycle start pulse, high exactly in ISSUE
//   md_num1, md_num2  operands to alu_muldiv
//   md_result         result from alu_muldiv, captured when busy is low
//   md_busy           alu_muldiv busy
// Parameters:
//   XLEN      operand/result width
//   MIN_WAIT  cycles after the start pulse before md_busy is first sampled (1..4)
// Build option:
//   MULDIV_RESULT_CACHE_EN  adds a one-entry result cache; hits skip alu_muldiv
module muldiv_issue
  import muldiv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int MIN_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_issue_if.slave     pipe,
  output muldiv_op_t        md_op,
  output logic              md_input_valid,
  output logic [XLEN-1:0]   md_num1,
  output logic [XLEN-1:0]   md_num2,
  input  logic [XLEN-1:0]   md_result,
  input  logic              md_busy
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(MIN_WAIT);

  issue_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]         resp_data_q;
  logic                    accept;
  logic                    capture;
  logic                    wait_over;
  logic                    cache_hit;
  logic [XLEN-1:0]         cache_data;

  // Flush blocks acceptance so a request racing a kill is retried later.
  assign accept = (state_q == S_IDLE) && pipe.req_valid && !pipe.flush;

  // The counter holds the cycles still to elapse including the current one,
  // so busy is first sampled MIN_WAIT cycles after the pulse cycle.
  assign wait_over = (cnt_q <= WAIT_CNT_W'(1)) && !md_busy;

`ifdef MULDIV_RESULT_CACHE_EN
  muldiv_result_cache #(
    .XLEN (XLEN)
  ) u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .invalidate (pipe.flush),
    .lookup_op  (pipe.req_op),
    .lookup_a   (pipe.req_a),
    .lookup_b   (pipe.req_b),
    .hit        (cache_hit),
    .hit_data   (cache_data),
    .fill_en    (capture),
    .fill_op    (md_op),
    .fill_a     (md_num1),
    .fill_b     (md_num2),
    .fill_data  (md_result)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = cache_hit ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        // The pulse is already on the wire this cycle; a flush here can
        // only turn the wait into a drain.
        cnt_d   = WAIT_LOAD;
        state_d = pipe.flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - WAIT_CNT_W'(1);
        if (pipe.flush) begin
          state_d = S_DRAIN;
        end else if (wait_over) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_DRAIN: begin
        // alu_muldiv cannot be aborted; let it finish and drop the result.
        if (cnt_q != '0) cnt_d = cnt_q - WAIT_CNT_W'(1);
        if (wait_over) state_d = S_IDLE;
      end
      S_RESP: begin
        if (pipe.flush || pipe.resp_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      md_op       <= MUL;
      md_num1     <= '0;
      md_num2     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Operands only move on a miss so alu_muldiv inputs stay untouched
      // while a cached result is being returned.
      if (accept && !cache_hit) begin
        md_op   <= pipe.req_op;
        md_num1 <= pipe.req_a;
        md_num2 <= pipe.req_b;
      end
      if (capture) begin
        resp_data_q <= md_result;
      end else if (accept && cache_hit) begin
        resp_data_q <= cache_data;
      end
    end
  end

  // Gate with rst_n: the state is already IDLE during reset, but the
  // pipeline must not see ready until reset is released.
  assign pipe.req_ready  = rst_n && (state_q == S_IDLE);
  assign pipe.resp_valid = (state_q == S_RESP);
  assign pipe.resp_data  = resp_data_q;
  assign md_input_valid  = (state_q == S_ISSUE);

endmodule

// File: doc/muldiv_issue.md
Name: muldiv_issue

Overview:
- Initiator side of the alu_muldiv op/input_valid/busy/result handshake.
- Sits in the execute stage between the pipeline's valid/ready request channel and one alu_muldiv instance.
- Registers operands, emits exactly one input_valid pulse per request, waits for busy to fall, captures result, and holds a response until the pipeline takes it.
- Supports flush. A killed operation is drained, never aborted.

Parameters:
- XLEN, 32, operand/result width.
- MIN_WAIT, 1, cycles after the input_valid pulse before md_busy is first sampled (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline has a muldiv op.
- req_ready  out  1  block can accept a request.
- req_op  in  3  muldiv_op_t (RISC-V funct3 encoding).
- req_a  in  XLEN  rs1 value.
- req_b  in  XLEN  rs2 value.
- resp_valid  out  1  resp_data holds a completed result.
- resp_ready  in  1  pipeline consumes the response.
- resp_data  out  XLEN  captured result.
- flush  in  1  kill the current/pending op.
- md_op  out  3  to alu_muldiv op.
- md_input_valid  out  1  one-cycle start pulse.
- md_num1  out  XLEN  to alu_muldiv num1.
- md_num2  out  XLEN  to alu_muldiv num2.
- md_result  in  XLEN  from alu_muldiv.
- md_busy  in  1  from alu_muldiv.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0 while rst_n=0; resp_valid=0; md_input_valid=0; md_op=0; md_num1=0; md_num2=0; resp_data=0; wait counter=0.
- Reset mid-operation returns to IDLE immediately. The bench must also reset alu_muldiv.
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: req_ready=1. On req_valid&&req_ready&&!flush, latch op/a/b into md_op/md_num1/md_num2 and go to ISSUE.
- ISSUE: md_input_valid=1 for exactly this cycle. Load counter=MIN_WAIT, go to WAIT. With flush in the same cycle, the pulse still goes out (already committed), then go to DRAIN.
- WAIT: decrement counter while nonzero, ignoring md_busy. Once counter==0 and md_busy==0:
  - capture md_result into resp_data;
  - go to RESP (resp_valid=1 next cycle).
- WAIT with flush: go to DRAIN.
- DRAIN: same counter/busy rule as WAIT, but discard the result and go to IDLE. req_ready=0.
- RESP: resp_valid=1; resp_data stable. On resp_ready, go to IDLE. Back-to-back acceptance is only possible the following cycle.
- RESP with flush: drop resp_valid and go to IDLE. flush has priority over resp_ready.
- md_num1, md_num2 and md_op stay stable from ISSUE until the block leaves WAIT/DRAIN.
- Minimum latency, req accept to resp_valid: MIN_WAIT+2 cycles when md_busy is never asserted.
- Result width is XLEN. No arithmetic is performed here; results pass through bit-exact.
- Flush in IDLE has no effect. A req_valid in the same cycle as flush is not accepted.

Optional Feature:
- Macro: MULDIV_RESULT_CACHE_EN.
- Defined: keep a tag {valid, op, a, b} plus the value of the last completed, non-flushed result.
  - An IDLE request matching the tag skips ISSUE/WAIT and goes straight to RESP with the cached value, so resp_valid appears 1 cycle after acceptance.
  - No md_input_valid pulse is generated for a hit.
  - The tag is invalidated on reset and on any flush.
- Undefined: no tag storage; every request issues to alu_muldiv.

Decomposition:
- muldiv_pkg holds:
  - muldiv_op_t, 3-bit: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7;
  - issue_state_t enum;
  - XLEN_DEFAULT=32.
- One natural sub-module, muldiv_result_cache: tag compare plus storage, instantiated only under MULDIV_RESULT_CACHE_EN.

Test Plan:
- MUL: req 7, 6, op=0. Expect one md_input_valid pulse, resp_data=42, resp_valid at ≥ MIN_WAIT+2 cycles.
- DIVU: 100/7 with a model holding md_busy=1 for 33 cycles. Expect resp_data=14 only after md_busy falls, and req_ready=0 throughout.
- DIV by zero: a=5, b=0. Expect resp_data=0xFFFFFFFF passed through unchanged.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid. Expect resp_valid and resp_data held; no new pulse; completion on resp_ready.
- Flush during WAIT of REM (busy high): no resp_valid; DRAIN until md_busy=0. The next request (MULHU 0xFFFFFFFF, 0xFFFFFFFF) returns 0xFFFFFFFE.
- With MULDIV_RESULT_CACHE_EN: repeat MUL 7, 6. Expect resp_valid 1 cycle after accept, zero md_input_valid pulses.
- rst_n low mid-WAIT: all outputs at reset values the same cycle.
